// File: rtl/i1_arb_pkg.sv
// Shared types and widths for the i1 decoder request arbiter.
package i1_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam int I1_PI_W = 25;
    localparam int I1_PO_W = 16;
    localparam int CNT_W   = 4;

endpackage

// File: rtl/i1_rr_arbiter.sv
// Combinational round-robin grant: the first set request at or after ptr wins.
module i1_rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W-1:0] idx;
    int               j;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        j       = 0;
        for (int k = 0; k < NREQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            idx = IDX_W'(j);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/i1_req_arbiter.sv
// Shares one i1 decode datapath among NREQ requesters: grant, drive, settle,
// capture, then return the result over a per-requester valid/ready handshake.
//
//   state   | meaning
//   IDLE    | arbitrating; req_ready offered to the round-robin winner
//   DRIVE   | pi_out driven, counting down the decoder settle interval
//   RESPOND | rsp_data captured, waiting for rsp_ready of the granted requester
module i1_req_arbiter
    import i1_arb_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int PI_W   = I1_PI_W,
    parameter int PO_W   = I1_PO_W,
    parameter int SETTLE = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*PI_W-1:0] req_data,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [PO_W-1:0]      rsp_data,
    output logic [PI_W-1:0]      pi_out,
    input  logic [PO_W-1:0]      po_in,
    output logic                 busy
);

    localparam int IDX_W = $clog2(NREQ);

    generate
        if (SETTLE < 1 || SETTLE > (1 << CNT_W) - 1) begin : g_bad_settle
            $error("i1_req_arbiter: SETTLE must be in 1..15");
        end
        if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
            $error("i1_req_arbiter: NREQ must be in 2..8");
        end
    endgenerate

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   gnt_idx;
    logic [IDX_W-1:0]   arb_idx;
    logic [NREQ-1:0]    arb_gnt;
    logic [CNT_W-1:0]   cnt;

    i1_rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // A grant in IDLE is itself the request handshake: the winner is always valid.
    assign req_ready = (state == IDLE) ? arb_gnt : '0;
    assign busy      = (state != IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt_idx   <= '0;
            cnt       <= '0;
            pi_out    <= '0;
            rsp_data  <= '0;
            rsp_valid <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|arb_gnt) begin
                        pi_out  <= req_data[int'(arb_idx)*PI_W +: PI_W];
                        gnt_idx <= arb_idx;
                        cnt     <= CNT_W'(SETTLE);
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        rsp_data  <= po_in;
                        rsp_valid <= NREQ'(1) << gnt_idx;
                        state     <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (rsp_ready[gnt_idx]) begin
                        rsp_valid <= '0;
                        ptr       <= (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i1_req_arbiter.sv
// Self-checking bench for i1_req_arbiter: transaction-level model plus directed pins.
module tb_i1_req_arbiter;

    localparam int NREQ = 4;
    localparam int PI_W = 25;
    localparam int PO_W = 16;
    localparam int SETTLE = 1;

    logic              clock = 1'b0;
    logic              reset_n;
    logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
    logic [NREQ*PI_W-1:0] req_data;
    logic [PO_W-1:0]   rsp_data, po_in;
    logic [PI_W-1:0]   pi_out;
    logic              busy;

    logic [NREQ-1:0]   req_valid3, req_ready3, rsp_valid3, rsp_ready3;
    logic [NREQ*PI_W-1:0] req_data3;
    logic [PO_W-1:0]   rsp_data3, po_in3;
    logic [PI_W-1:0]   pi_out3;
    logic              busy3;

    logic [NREQ-1:0]   n3_valid, n3_rr;
    logic [NREQ*PI_W-1:0] n3_data;
    logic [PO_W-1:0]   n3_po;

    always #5 clock = ~clock;

    i1_req_arbiter #(.NREQ(NREQ), .PI_W(PI_W), .PO_W(PO_W), .SETTLE(SETTLE)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .pi_out(pi_out), .po_in(po_in), .busy(busy)
    );

    i1_req_arbiter #(.NREQ(NREQ), .PI_W(PI_W), .PO_W(PO_W), .SETTLE(3)) dut3 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid3), .req_ready(req_ready3), .req_data(req_data3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_data(rsp_data3),
        .pi_out(pi_out3), .po_in(po_in3), .busy(busy3)
    );

    int checks = 0;
    int failures = 0;

    // Transaction model: one outstanding job, aged in edges since acceptance.
    int          m_active, m_gnt, m_age, m_rv, m_ptr;
    logic [24:0] m_pi;
    logic [15:0] m_rsp;
    int          grants[$];

    logic [3:0]  s_req_ready, s_rsp_valid, s3_req_ready;
    logic [15:0] s_rsp_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int winner(input logic [3:0] v);
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [3:0] exp_req_ready();
        int w;
        w = winner(req_valid);
        if (m_active == 0 && w >= 0) return 4'b0001 << w;
        return 4'b0000;
    endfunction

    function automatic logic [99:0] rand_data();
        logic [99:0] d;
        for (int i = 0; i < NREQ; i++) d[i*PI_W +: PI_W] = 25'($urandom);
        return d;
    endfunction

    task automatic model_reset();
        m_active = 0; m_gnt = 0; m_age = 0; m_rv = 0; m_ptr = 0;
        m_pi = '0; m_rsp = '0;
    endtask

    task automatic model_update();
        int w;
        if (m_active == 0) begin
            w = winner(req_valid);
            if (w >= 0) begin
                m_active = 1;
                m_gnt = w;
                m_pi = req_data[w*PI_W +: PI_W];
                m_age = 0;
                grants.push_back(w);
            end
        end else if (m_rv != 0) begin
            if (rsp_ready[m_gnt]) begin
                m_rv = 0;
                m_active = 0;
                m_ptr = (m_gnt + 1) % NREQ;
            end
        end else begin
            m_age++;
            if (m_age == SETTLE) begin
                m_rsp = po_in;
                m_rv = 1;
            end
        end
    endtask

    task automatic step(input logic [3:0] v, input logic [99:0] d, input logic [3:0] rr,
                        input logic [15:0] po);
        @(negedge clock);
        req_valid = v; req_data = d; rsp_ready = rr; po_in = po;
        req_valid3 = n3_valid; req_data3 = n3_data; rsp_ready3 = n3_rr; po_in3 = n3_po;
        #1;
        s_req_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_data = rsp_data;
        s3_req_ready = req_ready3;
        chk("req_ready", 32'(req_ready), 32'(exp_req_ready()));
        chk("rsp_valid", 32'(rsp_valid), (m_rv != 0) ? (32'd1 << m_gnt) : 32'd0);
        chk("rsp_data", 32'(rsp_data), 32'(m_rsp));
        chk("pi_out", 32'(pi_out), 32'(m_pi));
        chk("busy", 32'(busy), 32'(m_active != 0));
        @(posedge clock);
        model_update();
    endtask

    task automatic zero_inputs();
        req_valid = '0; req_data = '0; rsp_ready = '0; po_in = '0;
        n3_valid = '0; n3_data = '0; n3_rr = '0; n3_po = '0;
        req_valid3 = '0; req_data3 = '0; rsp_ready3 = '0; po_in3 = '0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        zero_inputs();
        model_reset();
        grants.delete();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_pi_out", 32'(pi_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  served;
        logic [99:0] d;
        reset_n = 1'b0;
        zero_inputs();
        model_reset();
        do_reset();

        // Single request from requester 1.
        d = 100'(25'h0080000) << PI_W;
        step(4'b0010, d, 4'hF, 16'h0042);
        chk("ss_req_ready", 32'(s_req_ready), 32'h2);
        #1;
        chk("ss_pi_out", 32'(pi_out), 32'h0080000);
        chk("ss_busy_hi", 32'(busy), 32'd1);
        step(4'b0000, '0, 4'hF, 16'h0042);
        #1;
        chk("ss_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("ss_rsp_data", 32'(rsp_data), 32'h0042);
        step(4'b0000, '0, 4'hF, 16'h0000);
        #1;
        chk("ss_busy_lo", 32'(busy), 32'd0);
        chk("ss_rsp_done", 32'(rsp_valid), 32'd0);

        // Simultaneous requests 0 and 2.
        do_reset();
        for (int i = 0; i < 40 && !(grants.size() == 2 && m_active == 0); i++) begin
            served = '0;
            foreach (grants[k]) served = served | (4'b0001 << grants[k]);
            step(4'b0101 & ~served, rand_data(), 4'hF, 16'($urandom));
        end
        chk("pair_count", 32'(grants.size()), 32'd2);
        if (grants.size() >= 2) begin
            chk("pair_first", 32'(grants[0]), 32'd0);
            chk("pair_second", 32'(grants[1]), 32'd2);
        end
        step(4'hF, rand_data(), 4'hF, 16'($urandom));
        chk("pair_ptr3", 32'(s_req_ready), 32'h8);

        // Fairness with everyone requesting.
        do_reset();
        for (int i = 0; i < 100 && grants.size() < 8; i++)
            step(4'hF, rand_data(), 4'hF, 16'($urandom));
        chk("fair_count", 32'(grants.size()), 32'd8);
        if (grants.size() >= 8)
            for (int i = 0; i < 8; i++) chk("fair_order", 32'(grants[i]), 32'(i % 4));

        // Backpressure on requester 3.
        do_reset();
        step(4'b1000, rand_data(), 4'h0, 16'h1234);
        step(4'b0111, rand_data(), 4'h0, 16'hBEEF);
        for (int i = 0; i < 5; i++) begin
            step(4'b0111, rand_data(), 4'b0111, 16'($urandom));
            chk("bp_no_ready", 32'(s_req_ready), 32'd0);
            chk("bp_valid", 32'(s_rsp_valid), 32'h8);
            chk("bp_data", 32'(s_rsp_data), 32'hBEEF);
        end
        step(4'b0111, rand_data(), 4'b1000, 16'($urandom));
        chk("bp_hs_no_ready", 32'(s_req_ready), 32'd0);
        step(4'b0111, rand_data(), 4'hF, 16'($urandom));
        chk("bp_next_ready", 32'(s_req_ready), 32'h1);

        // Randomised traffic.
        for (int i = 0; i < 300; i++)
            step(4'($urandom), rand_data(), 4'($urandom) | 4'($urandom), 16'($urandom));

        // Drain the main instance.
        for (int i = 0; i < 40 && m_active != 0; i++)
            step(4'h0, '0, 4'hF, 16'($urandom));
        chk("drain_idle", 32'(m_active), 32'd0);

        // SETTLE=3 sampling point on the second instance.
        n3_valid = 4'b0001; n3_data = 100'(25'h1ABCDE); n3_rr = 4'h0; n3_po = 16'h1111;
        step(4'h0, '0, 4'hF, 16'h0);
        chk("s3_req_ready", 32'(s3_req_ready), 32'h1);
        n3_valid = 4'h0; n3_po = 16'h2222;
        step(4'h0, '0, 4'hF, 16'h0);
        #1;
        chk("s3_pi_out", 32'(pi_out3), 32'h1ABCDE);
        chk("s3_valid_e1", 32'(rsp_valid3), 32'd0);
        n3_po = 16'h3333;
        step(4'h0, '0, 4'hF, 16'h0);
        #1;
        chk("s3_valid_e2", 32'(rsp_valid3), 32'd0);
        n3_po = 16'h4444;
        step(4'h0, '0, 4'hF, 16'h0);
        #1;
        chk("s3_valid_e3", 32'(rsp_valid3), 32'h1);
        chk("s3_data_e3", 32'(rsp_data3), 32'h4444);
        n3_po = 16'h5555;
        step(4'h0, '0, 4'hF, 16'h0);
        #1;
        chk("s3_data_hold", 32'(rsp_data3), 32'h4444);
        n3_rr = 4'b0001;
        step(4'h0, '0, 4'hF, 16'h0);
        #1;
        chk("s3_busy_lo", 32'(busy3), 32'd0);
        n3_rr = 4'h0;

        // Reset asserted while in DRIVE.
        step(4'b0001, rand_data(), 4'hF, 16'($urandom));
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_pi_out", 32'(pi_out), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        model_reset();
        zero_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        step(4'hF, rand_data(), 4'hF, 16'($urandom));
        chk("mid_prio0", 32'(s_req_ready), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
